mul_scheduler: RTL

Sequencing and arbitration controller that shares one combinational 8-bit array multiplier (low-byte product) between two requesters. Accepts operand pairs over a REQ/GNT handshake with round-robin arbitration. Drives registered operands into the multiplier and holds them for a programmable settle window, so the long ripple path through the array is a multicycle path. Captures the low 8 bits of the product and returns them to the winning requester with a one-cycle valid pulse.

---
 rtl/mul_scheduler.sv | 91 +++++++++
 1 files changed

// File: rtl/mul_scheduler.sv
// Round-robin sequencer sharing one combinational array multiplier between two requesters.
// Operands are registered and held for SETTLE cycles so the multiplier path can be multicycle.
module mul_scheduler #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SETTLE = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             gnt0,
  output logic             valid0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt1,
  output logic             valid1,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic [WIDTH-1:0] mul_result,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [3:0] CntInit = 4'(SETTLE - 1);

  state_e     state_q;
  logic       owner_q;
  logic       last_q;
  logic [3:0] cnt_q;
  logic       win;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    win = req1;
    if (req0 && req1) begin
      win = ~last_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      result  <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      valid0  <= 1'b0;
      valid1  <= 1'b0;
    end else begin
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      valid0 <= 1'b0;
      valid1 <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req0 || req1) begin
            mul_a   <= win ? a1 : a0;
            mul_b   <= win ? b1 : b0;
            owner_q <= win;
            last_q  <= win;
            cnt_q   <= CntInit;
            gnt0    <= ~win;
            gnt1    <= win;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (cnt_q == 4'd0) begin
            result  <= mul_result;
            valid0  <= ~owner_q;
            valid1  <= owner_q;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
      endcase
    end
  end

  assign busy = (state_q == StRun);

endmodule
